// File: rtl/spi_iccm_pkg.sv
// -----------------------------------------------------------------------------
// spi_iccm_pkg
// Shared definitions for the SPI ICCM image loader (transmit side).
//   END_WORD        : end-of-program marker, identical on the receiver side
//   SCK_CNT_W       : width of the SCK half-period down-counter
//   loader_state_e  : loader FSM state encoding
//   byte_swap()     : word byte reversal applied before shifting
// -----------------------------------------------------------------------------
package spi_iccm_pkg;

  localparam logic [31:0] END_WORD  = 32'h7F87_8000;
  localparam int          SCK_CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    FETCH,
    SHIFT,
    ENDW,
    ACK,
    DONE
  } loader_state_e;

  // The receiver reverses the bytes again, so the ICCM sees the original word.
  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// -----------------------------------------------------------------------------
// spi_sck_gen
// SCK divider. While en is low the generator is parked at the start of a low
// phase. Once enabled it runs low for CLK_DIV cycles, then (if pulse_ok) high
// for CLK_DIV cycles, and repeats. With pulse_ok low it keeps timing low
// phases without rising, which the loader uses for the CSB setup delay and to
// stop after the last pulse.
// Ports:
//   clk_i, rst_i  : clock, async active-high reset
//   en            : run the divider
//   pulse_ok      : allow a rising edge at the end of the current low phase
//   sck           : registered SPI clock, idles low
//   rise_stb      : this cycle's edge makes sck rise
//   fall_stb      : this cycle's edge makes sck fall
//   low_end_stb   : this is the last cycle of a low phase
// -----------------------------------------------------------------------------
module spi_sck_gen
  import spi_iccm_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en,
  input  logic pulse_ok,
  output logic sck,
  output logic rise_stb,
  output logic fall_stb,
  output logic low_end_stb
);

  localparam logic [SCK_CNT_W-1:0] DIV_M1 = SCK_CNT_W'(CLK_DIV - 1);

  logic [SCK_CNT_W-1:0] div_cnt;
  logic                 div_tc;

  assign div_tc      = (div_cnt == '0);
  assign fall_stb    = en &&  sck && div_tc;
  assign low_end_stb = en && !sck && div_tc;
  assign rise_stb    = low_end_stb && pulse_ok;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sck     <= 1'b0;
      div_cnt <= DIV_M1;
    end else if (!en) begin
      sck     <= 1'b0;
      div_cnt <= DIV_M1;
    end else if (!div_tc) begin
      div_cnt <= div_cnt - 1'b1;
    end else begin
      div_cnt <= DIV_M1;
      if (sck) begin
        sck <= 1'b0;
      end else if (pulse_ok) begin
        sck <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_iccm_loader_tx.sv
// -----------------------------------------------------------------------------
// spi_iccm_loader_tx
// SPI master that streams num_words words from a local memory to a remote ICCM
// boot receiver (byte-swapped, MSB first), sends END_WORD raw, then clocks
// ACK_CLKS extra pulses and polls sdi_i for the "program received" flag.
//
// state | meaning
// IDLE  | waiting for start_i
// SETUP | csb low, sck low for CLK_DIV cycles before the first pulse
// FETCH | rreq pulse issued, waiting for rvalid_i (sck held low)
// SHIFT | 32 pulses of the current image word
// ENDW  | 32 pulses of END_WORD
// ACK   | ACK_CLKS pulses, sdi_i sampled at the end of each following low phase
// DONE  | csb high, done pulse, back to IDLE
//
// Ports:
//   clk_i, rst_i            : clock, async active-high reset
//   start_i, num_words_i    : start pulse and word count (captured on start)
//   raddr_o, rreq_o         : source memory read address / request pulse
//   rdata_i, rvalid_i       : source memory read data / valid
//   sck_o, csb_o, sdo_o     : SPI clock, chip select (active-low), data out
//   sdi_i                   : receiver status, 1 = end word seen
//   busy_o, done_o, ack_o   : transfer active, completion pulse, sticky ack
// -----------------------------------------------------------------------------
module spi_iccm_loader_tx
  import spi_iccm_pkg::*;
#(
  parameter int ADDR_WIDTH = 13,
  parameter int CLK_DIV    = 4,
  parameter int ACK_CLKS   = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH:0]   num_words_i,
  output logic [ADDR_WIDTH-1:0] raddr_o,
  output logic                  rreq_o,
  input  logic [31:0]           rdata_i,
  input  logic                  rvalid_i,
  output logic                  sck_o,
  output logic                  csb_o,
  output logic                  sdo_o,
  input  logic                  sdi_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  ack_o
);

  localparam logic [ADDR_WIDTH:0]   REM_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [3:0]            ACK_N    = 4'(ACK_CLKS);

  loader_state_e       state;
  logic [ADDR_WIDTH:0] remaining;
  logic [31:0]         shreg;
  logic [4:0]          bit_cnt;
  logic [3:0]          ack_left;
  logic                ack_pending;
  logic                req_pending;
  logic [31:0]         rdata_swapped;

  logic sck_en;
  logic sck_pulse_ok;
  logic sck_rise;
  logic sck_fall;
  logic sck_low_end;

  assign rdata_swapped = byte_swap(rdata_i);

  always_comb begin
    sck_en       = 1'b0;
    sck_pulse_ok = 1'b0;
    case (state)
      SETUP: sck_en = 1'b1;
      SHIFT, ENDW: begin
        sck_en       = 1'b1;
        sck_pulse_ok = 1'b1;
      end
      ACK: begin
        sck_en       = 1'b1;
        sck_pulse_ok = (ack_left != '0);
      end
      default: ;
    endcase
  end

  spi_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en          (sck_en),
    .pulse_ok    (sck_pulse_ok),
    .sck         (sck_o),
    .rise_stb    (sck_rise),
    .fall_stb    (sck_fall),
    .low_end_stb (sck_low_end)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      remaining   <= '0;
      shreg       <= '0;
      bit_cnt     <= '0;
      ack_left    <= '0;
      ack_pending <= 1'b0;
      req_pending <= 1'b0;
      raddr_o     <= '0;
      rreq_o      <= 1'b0;
      csb_o       <= 1'b1;
      sdo_o       <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      ack_o       <= 1'b0;
    end else begin
      rreq_o <= 1'b0;
      done_o <= 1'b0;

      case (state)
        IDLE: ;

        SETUP: begin
          if (sck_low_end) begin
            if (remaining != '0) begin
              state       <= FETCH;
              rreq_o      <= 1'b1;
              req_pending <= 1'b1;
            end else begin
              state   <= ENDW;
              shreg   <= END_WORD;
              sdo_o   <= END_WORD[31];
              bit_cnt <= 5'd31;
            end
          end
        end

        FETCH: begin
          // rreq_o is still high in the first FETCH cycle, so a valid seen
          // there cannot belong to this request.
          if (req_pending && !rreq_o && rvalid_i) begin
            req_pending <= 1'b0;
            shreg       <= rdata_swapped;
            sdo_o       <= rdata_swapped[31];
            bit_cnt     <= 5'd31;
            state       <= SHIFT;
          end
        end

        SHIFT: begin
          if (sck_fall) begin
            if (bit_cnt != '0) begin
              sdo_o   <= shreg[30];
              shreg   <= {shreg[30:0], 1'b0};
              bit_cnt <= bit_cnt - 1'b1;
            end else begin
              raddr_o   <= raddr_o + ADDR_ONE;
              remaining <= remaining - REM_ONE;
              if (remaining == REM_ONE) begin
                state   <= ENDW;
                shreg   <= END_WORD;
                sdo_o   <= END_WORD[31];
                bit_cnt <= 5'd31;
              end else begin
                state       <= FETCH;
                sdo_o       <= 1'b0;
                rreq_o      <= 1'b1;
                req_pending <= 1'b1;
              end
            end
          end
        end

        ENDW: begin
          if (sck_fall) begin
            if (bit_cnt != '0) begin
              sdo_o   <= shreg[30];
              shreg   <= {shreg[30:0], 1'b0};
              bit_cnt <= bit_cnt - 1'b1;
            end else begin
              state       <= ACK;
              sdo_o       <= 1'b0;
              ack_left    <= ACK_N;
              ack_pending <= 1'b0;
            end
          end
        end

        ACK: begin
          // A low_end that also rises closes the previous pulse's sample
          // window and opens the next one; the later assignment wins.
          if (sck_low_end && ack_pending) begin
            ack_pending <= 1'b0;
            if (sdi_i) begin
              ack_o <= 1'b1;
            end
            if (ack_left == '0) begin
              state  <= DONE;
              csb_o  <= 1'b1;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end
          end
          if (sck_rise) begin
            ack_left    <= ack_left - 1'b1;
            ack_pending <= 1'b1;
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase

      // busy_o is already low in DONE, so a start there is accepted too.
      if ((state == IDLE || state == DONE) && start_i) begin
        state       <= SETUP;
        remaining   <= num_words_i;
        raddr_o     <= '0;
        ack_o       <= 1'b0;
        busy_o      <= 1'b1;
        csb_o       <= 1'b0;
        sdo_o       <= 1'b0;
        req_pending <= 1'b0;
      end
    end
  end

endmodule
